// File: rtl/tx_fifo_gowin.sv
// Elastic FWFT TX buffer between the RIFFA TX stage and the Gowin PCIe TL TX port, with framing/mask checks.
// Optional feature macro: GOWIN_TX_PKT_COUNT_EN adds TX_PKT_COUNT (popped end-of-packet beats).
module tx_fifo_gowin #(
   parameter int C_PCI_DATA_WIDTH = 256,
   parameter int C_DEPTH          = 4
) (
   input  logic                        CLK,
   input  logic                        RST_IN,
   input  logic [C_PCI_DATA_WIDTH-1:0] S_TLP_DATA,
   input  logic [7:0]                  S_TLP_VALID,
   input  logic                        S_TLP_SOP,
   input  logic                        S_TLP_EOP,
   output logic                        S_TLP_READY,
   output logic [C_PCI_DATA_WIDTH-1:0] TL_TX_DATA,
   output logic [7:0]                  TL_TX_VALID,
   output logic                        TL_TX_SOP,
   output logic                        TL_TX_EOP,
   input  logic                        TL_TX_WAIT,
   output logic [$clog2(C_DEPTH):0]    FIFO_LEVEL,
   output logic                        FRAME_ERR
`ifdef GOWIN_TX_PKT_COUNT_EN
   ,
   output logic [31:0]                 TX_PKT_COUNT
`endif
);

   localparam int AW = $clog2(C_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(C_DEPTH);

   if (C_DEPTH < 2 || (C_DEPTH & (C_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tx_fifo_gowin: C_DEPTH must be a power of 2 and >= 2");
   end

   typedef struct packed {
      logic [C_PCI_DATA_WIDTH-1:0] data;
      logic [7:0]                  mask;
      logic                        sop;
      logic                        eop;
   } entry_t;

   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

   entry_t        mem_q [C_DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;
   state_t        state_q, state_d;
   logic          accept, empty, pop, push, frame_ok, err_set, mask_legal, mask_bad;

   assign accept = (|S_TLP_VALID) && ready_q;
   assign empty  = (level_q == '0);
   assign pop    = !TL_TX_WAIT && !empty;

   always_comb begin
      mask_legal = 1'b0;
      case (S_TLP_VALID)
         8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: mask_legal = 1'b1;
         default: mask_legal = 1'b0;
      endcase
   end
   // Every non-final beat must be full; mask errors flag but do not drop the beat.
   assign mask_bad = !mask_legal || (!S_TLP_EOP && S_TLP_VALID != 8'hFF);

   // Framing FSM: state register / next state / outputs.
   always_ff @(posedge CLK or negedge RST_IN) begin
      if (!RST_IN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            IDLE: if (S_TLP_SOP && !S_TLP_EOP) state_d = PKT;
            PKT:  if (!S_TLP_SOP && S_TLP_EOP) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      frame_ok = (state_q == IDLE) ? S_TLP_SOP : !S_TLP_SOP;
      push     = accept && frame_ok;
      err_set  = accept && (!frame_ok || mask_bad);
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      // Registered ready: looks at the post-edge level so a full FIFO can never be pushed.
      ready_d = (level_d < DEPTH_L);
      err_d   = err_q | err_set;
   end

   always_ff @(posedge CLK or negedge RST_IN) begin
      if (!RST_IN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: outputs are gated while empty.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= '{data: S_TLP_DATA, mask: S_TLP_VALID, sop: S_TLP_SOP, eop: S_TLP_EOP};
   end

   assign head        = mem_q[rd_ptr_q];
   assign TL_TX_DATA  = empty ? '0 : head.data;
   assign TL_TX_VALID = empty ? '0 : head.mask;
   assign TL_TX_SOP   = !empty && head.sop;
   assign TL_TX_EOP   = !empty && head.eop;
   assign S_TLP_READY = ready_q;
   assign FIFO_LEVEL  = level_q;
   assign FRAME_ERR   = err_q;

`ifdef GOWIN_TX_PKT_COUNT_EN
   logic [31:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = (pop && head.eop) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
   end

   always_ff @(posedge CLK or negedge RST_IN) begin
      if (!RST_IN) pkt_cnt_q <= '0;
      else         pkt_cnt_q <= pkt_cnt_d;
   end

   assign TX_PKT_COUNT = pkt_cnt_q;
`endif

endmodule
